mu_mem_read_arbiter: RTL and testbench

- Shares one memory read port among the MatrixUnit's three address-request channels: input, weight and bias.
- Arbitration is round-robin. Every granted request is tagged with its source. In-order memory responses are routed back to the matching DataResponse channel.
- Sits between MatrixUnit and the global-buffer/memory read interface in the matrix-unit subsystem.

---
 rtl/mu_mem_read_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mu_mem_read_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_mem_read_arbiter.sv
// Round-robin arbiter sharing one memory read port among input, weight and
// bias request channels; a source-tag FIFO routes in-order responses back.
module mu_mem_read_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int MAX_OUT = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_req_vld,
  output logic                       in_req_rdy,
  input  logic [ADDR_W-1:0]          in_req_dat,
  input  logic                       wgt_req_vld,
  output logic                       wgt_req_rdy,
  input  logic [ADDR_W-1:0]          wgt_req_dat,
  input  logic                       bias_req_vld,
  output logic                       bias_req_rdy,
  input  logic [ADDR_W-1:0]          bias_req_dat,
  output logic                       in_rsp_vld,
  input  logic                       in_rsp_rdy,
  output logic [DATA_W-1:0]          in_rsp_dat,
  output logic                       wgt_rsp_vld,
  input  logic                       wgt_rsp_rdy,
  output logic [DATA_W-1:0]          wgt_rsp_dat,
  output logic                       bias_rsp_vld,
  input  logic                       bias_rsp_rdy,
  output logic [DATA_W-1:0]          bias_rsp_dat,
  output logic                       mem_req_vld,
  input  logic                       mem_req_rdy,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_rsp_vld,
  output logic                       mem_rsp_rdy,
  input  logic [DATA_W-1:0]          mem_rsp_dat,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       rsp_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

  logic [2:0]        req_v;
  logic [1:0]        ptr;
  logic [1:0]        lock_src;
  logic              lock;
  logic [1:0]        ord0, ord1, ord2;
  logic [1:0]        sel;
  logic              sel_v;
  logic [ADDR_W-1:0] sel_addr;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        tag_mem [MAX_OUT];
  logic [1:0]        head;
  logic              full, empty;
  logic              grant_ok, rsp_ok;
  logic              push, pop;
  logic              head_rdy;

  assign req_v = {bias_req_vld, wgt_req_vld, in_req_vld};

  // Search order starts at the pointer and wraps around the three sources
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    unique case (ptr)
      2'd1: begin
        ord0 = 2'd1;
        ord1 = 2'd2;
        ord2 = 2'd0;
      end
      2'd2: begin
        ord0 = 2'd2;
        ord1 = 2'd0;
        ord2 = 2'd1;
      end
      default: begin
        ord0 = 2'd0;
        ord1 = 2'd1;
        ord2 = 2'd2;
      end
    endcase
  end

  always_comb begin
    sel = ord0;
    if (lock)
      sel = lock_src;
    else if (req_v[ord0])
      sel = ord0;
    else if (req_v[ord1])
      sel = ord1;
    else if (req_v[ord2])
      sel = ord2;
  end

  always_comb begin
    sel_v    = in_req_vld;
    sel_addr = in_req_dat;
    unique case (sel)
      2'd1: begin
        sel_v    = wgt_req_vld;
        sel_addr = wgt_req_dat;
      end
      2'd2: begin
        sel_v    = bias_req_vld;
        sel_addr = bias_req_dat;
      end
      default: begin
        sel_v    = in_req_vld;
        sel_addr = in_req_dat;
      end
    endcase
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign grant_ok     = rstn & mem_req_rdy & ~full;
  assign mem_req_vld  = rstn & sel_v & ~full;
  assign mem_req_addr = sel_addr;
  assign in_req_rdy   = grant_ok & (sel == 2'd0);
  assign wgt_req_rdy  = grant_ok & (sel == 2'd1);
  assign bias_req_rdy = grant_ok & (sel == 2'd2);
  assign push         = mem_req_vld & mem_req_rdy;

  assign head   = tag_mem[rd_ptr];
  assign rsp_ok = rstn & mem_rsp_vld & ~empty;

  assign in_rsp_vld   = rsp_ok & (head == 2'd0);
  assign wgt_rsp_vld  = rsp_ok & (head == 2'd1);
  assign bias_rsp_vld = rsp_ok & (head == 2'd2);
  assign in_rsp_dat   = mem_rsp_dat;
  assign wgt_rsp_dat  = mem_rsp_dat;
  assign bias_rsp_dat = mem_rsp_dat;

  always_comb begin
    head_rdy = in_rsp_rdy;
    unique case (head)
      2'd1:    head_rdy = wgt_rsp_rdy;
      2'd2:    head_rdy = bias_rsp_rdy;
      default: head_rdy = in_rsp_rdy;
    endcase
  end

  assign mem_rsp_rdy = rstn & ~empty & head_rdy;
  assign pop         = mem_rsp_vld & mem_rsp_rdy;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= 2'd0;
      lock     <= 1'b0;
      lock_src <= 2'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      // A stalled grant is frozen so address and tag stay stable
      if (push) begin
        ptr    <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        lock   <= 1'b0;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (mem_req_vld) begin
        lock     <= 1'b1;
        lock_src <= sel;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (mem_rsp_vld && empty)
        rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mu_mem_read_arbiter.sv
// Bench for mu_mem_read_arbiter: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_mu_mem_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int MO = 8;
  localparam int CW = $clog2(MO) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic [2:0]    rq_v = '0;
  logic [AW-1:0] rq_a [3];
  logic [2:0]    rs_r = '0;
  logic          mrdy = 1'b0;
  logic          rspv = 1'b0;
  logic [DW-1:0] mem_rsp_dat = '0;

  logic          in_req_rdy, wgt_req_rdy, bias_req_rdy;
  logic          in_rsp_vld, wgt_rsp_vld, bias_rsp_vld;
  logic [DW-1:0] in_rsp_dat, wgt_rsp_dat, bias_rsp_dat;
  logic          mem_req_vld, mem_rsp_rdy, rsp_err;
  logic [AW-1:0] mem_req_addr;
  logic [CW-1:0] outstanding;

  wire [2:0]    rq_r = {bias_req_rdy, wgt_req_rdy, in_req_rdy};
  wire [2:0]    rs_v = {bias_rsp_vld, wgt_rsp_vld, in_rsp_vld};
  wire [DW-1:0] rs_d [3];
  assign rs_d[0] = in_rsp_dat;
  assign rs_d[1] = wgt_rsp_dat;
  assign rs_d[2] = bias_rsp_dat;

  mu_mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rstn(rstn),
    .in_req_vld(rq_v[0]), .in_req_rdy(in_req_rdy), .in_req_dat(rq_a[0]),
    .wgt_req_vld(rq_v[1]), .wgt_req_rdy(wgt_req_rdy), .wgt_req_dat(rq_a[1]),
    .bias_req_vld(rq_v[2]), .bias_req_rdy(bias_req_rdy),
    .bias_req_dat(rq_a[2]),
    .in_rsp_vld(in_rsp_vld), .in_rsp_rdy(rs_r[0]), .in_rsp_dat(in_rsp_dat),
    .wgt_rsp_vld(wgt_rsp_vld), .wgt_rsp_rdy(rs_r[1]),
    .wgt_rsp_dat(wgt_rsp_dat),
    .bias_rsp_vld(bias_rsp_vld), .bias_rsp_rdy(rs_r[2]),
    .bias_rsp_dat(bias_rsp_dat),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mrdy),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_vld(rspv), .mem_rsp_rdy(mem_rsp_rdy),
    .mem_rsp_dat(mem_rsp_dat),
    .outstanding(outstanding), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_rr;
  int m_held;
  int m_q[$];
  bit m_err;

  int e_sel;
  bit e_any, e_mvld, e_push, e_pop;

  typedef struct {
    logic [2:0]    v;
    logic          mrdy;
    logic          rspv;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_out;
    logic [2:0]    e_rsp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_held = -1;
    m_q.delete();
    m_err = 0;
    e_push = 0;
    e_sel = 0;
  endtask

  task automatic check_model();
    int s;
    int h;
    bit full;
    full = (m_q.size() == MO);
    e_any = 0;
    e_sel = 0;
    if (m_held >= 0) begin
      e_sel = m_held;
      e_any = rq_v[m_held];
    end else begin
      for (int k = 0; k < 3; k++) begin
        s = (m_rr + k) % 3;
        if (!e_any && rq_v[s]) begin
          e_any = 1;
          e_sel = s;
        end
      end
    end
    e_mvld = e_any && !full;
    chk("mem_req_vld", mem_req_vld, e_mvld);
    if (e_any) begin
      chk("mem_req_addr", mem_req_addr, rq_a[e_sel]);
      for (int k = 0; k < 3; k++)
        chk("req_rdy", rq_r[k], (k == e_sel) && mrdy && !full);
    end
    if (m_q.size() > 0) begin
      h = m_q[0];
      for (int k = 0; k < 3; k++)
        chk("rsp_vld", rs_v[k], (k == h) && rspv);
      chk("mem_rsp_rdy", mem_rsp_rdy, rs_r[h]);
      if (rspv)
        chk("rsp_dat", rs_d[h], mem_rsp_dat);
      e_pop = rspv && rs_r[h];
    end else begin
      chk("rsp_vld_empty", rs_v, 0);
      chk("mem_rsp_rdy_empty", mem_rsp_rdy, 0);
      e_pop = 0;
    end
    chk("outstanding", outstanding, m_q.size());
    chk("rsp_err", rsp_err, m_err);
    e_push = e_mvld && mrdy;
  endtask

  task automatic update_model();
    if (m_q.size() == 0 && rspv)
      m_err = 1;
    if (e_pop)
      void'(m_q.pop_front());
    if (e_push) begin
      m_q.push_back(e_sel);
      m_rr = (e_sel + 1) % 3;
      m_held = -1;
    end else if (e_mvld) begin
      m_held = e_sel;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic cycle();
    settle();
    adv();
  endtask

  task automatic drain();
    rq_v = '0;
    rs_r = 3'b111;
    rspv = 1'b1;
    for (int n = 0; n < 40 && m_q.size() > 0; n++)
      cycle();
    chk("drain_done", m_q.size(), 0);
    rspv = 1'b0;
  endtask

  initial begin
    tbl[0] = '{3'b111, 1'b1, 1'b0, 32'h100, 4'd0, 3'b000};
    tbl[1] = '{3'b111, 1'b1, 1'b1, 32'h200, 4'd1, 3'b001};
    tbl[2] = '{3'b111, 1'b1, 1'b1, 32'h300, 4'd1, 3'b010};
    tbl[3] = '{3'b111, 1'b1, 1'b1, 32'h100, 4'd1, 3'b100};
    tbl[4] = '{3'b111, 1'b1, 1'b1, 32'h200, 4'd1, 3'b001};
    tbl[5] = '{3'b111, 1'b1, 1'b1, 32'h300, 4'd1, 3'b010};
    tbl[6] = '{3'b000, 1'b1, 1'b1, 32'h0,   4'd1, 3'b100};

    model_reset();
    rq_a[0] = 32'h100;
    rq_a[1] = 32'h200;
    rq_a[2] = 32'h300;

    // reset state with every input asserted
    rq_v = 3'b111;
    mrdy = 1'b1;
    rspv = 1'b1;
    rs_r = 3'b111;
    @(posedge clk);
    #1;
    chk("rst_mem_req_vld", mem_req_vld, 0);
    chk("rst_req_rdy", rq_r, 0);
    chk("rst_rsp_vld", rs_v, 0);
    chk("rst_mem_rsp_rdy", mem_rsp_rdy, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // round-robin with prompt responses
    for (int i = 0; i < 7; i++) begin
      rq_v = tbl[i].v;
      mrdy = tbl[i].mrdy;
      rspv = tbl[i].rspv;
      mem_rsp_dat = {224'h0, 32'hD0 + 32'(i)};
      settle();
      if (tbl[i].v != 0)
        chk("tbl_addr", mem_req_addr, tbl[i].e_addr);
      chk("tbl_outstanding", outstanding, tbl[i].e_out);
      chk("tbl_rsp_vld", rs_v, tbl[i].e_rsp);
      adv();
    end
    rspv = 1'b0;
    chk("tbl_end_empty", m_q.size(), 0);

    // fill to MAX_OUT, then one pop re-enables requests a cycle later
    rq_v = 3'b001;
    mrdy = 1'b1;
    for (int i = 0; i < MO; i++)
      cycle();
    settle();
    chk("full_outstanding", outstanding, MO);
    chk("full_mem_req_vld", mem_req_vld, 0);
    chk("full_in_rdy", in_req_rdy, 0);
    adv();
    rspv = 1'b1;
    mem_rsp_dat = {8{32'hCAFE0001}};
    settle();
    chk("pop_same_cycle_vld", mem_req_vld, 0);
    chk("pop_mem_rsp_rdy", mem_rsp_rdy, 1);
    adv();
    rspv = 1'b0;
    settle();
    chk("after_pop_outstanding", outstanding, MO - 1);
    chk("after_pop_vld", mem_req_vld, 1);
    adv();
    drain();

    // stalled grant stays on weight while input arrives
    rq_v = 3'b010;
    mrdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1)
        rq_v[0] = 1'b1;
      settle();
      chk("lock_addr", mem_req_addr, 32'h200);
      chk("lock_in_rdy", in_req_rdy, 0);
      adv();
    end
    mrdy = 1'b1;
    settle();
    chk("lock_accept_addr", mem_req_addr, 32'h200);
    chk("lock_accept_rdy", wgt_req_rdy, 1);
    adv();
    rq_v = 3'b101;
    settle();
    chk("next_bias", mem_req_addr, 32'h300);
    adv();
    rq_v = 3'b001;
    settle();
    chk("then_in", mem_req_addr, 32'h100);
    adv();
    drain();

    // bias at head blocks while bias client is not ready
    rq_v = 3'b100;
    mrdy = 1'b1;
    cycle();
    rq_v = 3'b000;
    rspv = 1'b1;
    rs_r = 3'b001;
    mem_rsp_dat = {8{32'hB1A5B1A5}};
    settle();
    chk("hol_mem_rsp_rdy", mem_rsp_rdy, 0);
    chk("hol_in_vld", in_rsp_vld, 0);
    chk("hol_bias_vld", bias_rsp_vld, 1);
    adv();
    rs_r = 3'b111;
    settle();
    chk("hol_release_rdy", mem_rsp_rdy, 1);
    chk("hol_bias_dat", bias_rsp_dat, {8{32'hB1A5B1A5}});
    adv();
    rspv = 1'b0;
    settle();
    chk("hol_popped", outstanding, 0);
    adv();

    // random traffic honouring requester hold rules
    rq_v = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < 3; s++) begin
        if (!(rq_v[s] && !(e_push && e_sel == s))) begin
          rq_v[s] = ($urandom_range(0, 1) == 1);
          rq_a[s] = $urandom;
        end
      end
      mrdy = ($urandom_range(0, 3) != 0);
      rspv = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      rs_r = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
      mem_rsp_dat = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    drain();

    // response with nothing outstanding sets sticky error
    rspv = 1'b1;
    settle();
    chk("err_pre", rsp_err, 0);
    chk("err_no_rdy", mem_rsp_rdy, 0);
    adv();
    rspv = 1'b0;
    settle();
    chk("err_set", rsp_err, 1);
    adv();
    cycle();
    settle();
    chk("err_sticky", rsp_err, 1);
    adv();

    // asynchronous reset in the middle of traffic
    rq_v = 3'b111;
    mrdy = 1'b1;
    cycle();
    cycle();
    rspv = 1'b1;
    settle();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_outstanding", outstanding, 0);
    chk("arst_rsp_err", rsp_err, 0);
    chk("arst_mem_req_vld", mem_req_vld, 0);
    chk("arst_req_rdy", rq_r, 0);
    chk("arst_rsp_vld", rs_v, 0);
    chk("arst_mem_rsp_rdy", mem_rsp_rdy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rq_v = '0;
    rspv = 1'b1;
    cycle();
    rspv = 1'b0;
    settle();
    chk("post_rst_err", rsp_err, 1);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
